// File: rtl/pow_arbiter.sv
// ---------------------------------------------------------------------------
// pow_arbiter
//
// Shares one `pow` pipeline between NUM_REQ requesters. A round-robin search
// picks one requester per accepted beat. The winner's ID is pushed into an
// in-order tag FIFO, so each `pow` result can be steered back to the
// requester that issued it. The response path back-pressures `pow` using
// the ready of whichever requester owns the head tag.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   req_valid/ready per-requester operand handshake
//   req_data        packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/ready per-requester result handshake
//   rsp_data        pow_data_out broadcast to every lane
//   pow_data_in/valid_in/ready_in    operand handshake towards `pow`
//   pow_data_out/valid_out/ready_out result handshake from `pow`
//   outstanding     tag FIFO occupancy
//   idle            no operations in flight
//   err_orphan      sticky: a `pow` result arrived with no tag to match it
// ---------------------------------------------------------------------------

package cnn1d_pkg;
    localparam int DATA_WIDTH = 16;
endpackage

module pow_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = cnn1d_pkg::DATA_WIDTH,
    parameter int TAG_DEPTH  = 8,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         pow_data_in,
    output logic                          pow_valid_in,
    input  logic                          pow_ready_in,
    input  logic [DATA_WIDTH-1:0]         pow_data_out,
    input  logic                          pow_valid_out,
    output logic                          pow_ready_out,
    output logic [CNT_W-1:0]              outstanding,
    output logic                          idle,
    output logic                          err_orphan
);

    localparam int PTR_W = $clog2(TAG_DEPTH);

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  orphan_q;

    logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];
    logic [ID_W-1:0]       grant;
    logic [ID_W-1:0]       cand;
    logic                  found;
    logic [ID_W-1:0]       next_rr;
    logic [ID_W-1:0]       head;
    logic                  any_valid;
    logic                  full;
    logic                  nonempty;
    logic                  issue;
    logic                  retire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign any_valid = |req_valid;
    assign full      = (count == CNT_W'(TAG_DEPTH));
    assign nonempty  = (count != '0);
    assign head      = tag_mem[rd_ptr];

    // All handshakes are gated by rst so nothing moves while reset is held,
    // even though the state itself only clears on the clock edge.
    assign issue     = rst && any_valid && pow_ready_in && !full;
    assign retire    = pow_valid_out && pow_ready_out;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = rr_ptr;
        cand  = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // NUM_REQ need not be a power of two, so the wrap is explicit.
    assign next_rr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign pow_valid_in = rst && any_valid && !full;
    assign pow_data_in  = lane_data[grant];

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Only the lane owning the head tag sees the result; with an empty FIFO
    // the result is an orphan and is neither presented nor accepted.
    always_comb begin
        rsp_valid = '0;
        if (rst && pow_valid_out && nonempty) begin
            rsp_valid[head] = 1'b1;
        end
    end

    assign pow_ready_out = rst && nonempty && rsp_ready[head];
    assign rsp_data      = {NUM_REQ{pow_data_out}};

    assign outstanding   = rst ? count : '0;
    assign idle          = !rst || (count == '0);
    assign err_orphan    = orphan_q;

    // Tag FIFO, round-robin pointer and sticky orphan flag. Pointers wrap
    // naturally because TAG_DEPTH is a power of two. Push is already blocked
    // by `full`, so a pop in a full cycle simply lowers the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (issue) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + 1'b1;
                rr_ptr          <= next_rr;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue && !retire) begin
                count <= count + 1'b1;
            end else if (!issue && retire) begin
                count <= count - 1'b1;
            end
            if (pow_valid_out && !nonempty) begin
                orphan_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pow_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pow_arbiter
//
// Drives pow_arbiter (NUM_REQ=4, DATA_WIDTH=16, TAG_DEPTH=8) from four
// operand sources, with a behavioural cube pipeline standing in for `pow`.
// A negedge monitor predicts every handshake from its own round-robin model
// and keeps a scoreboard of expected results in issue order.
// ---------------------------------------------------------------------------

module tb_pow_arbiter;

    localparam int NR      = 4;
    localparam int DW      = 16;
    localparam int POW_LAT = 3;
    localparam int POW_CAP = 16;

    typedef struct {
        logic [1:0]  lane;
        logic [15:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    req_valid;
    logic [63:0]   req_data;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic [63:0]   rsp_data;
    logic [3:0]    rsp_ready = 4'hF;
    logic [15:0]   pow_data_in;
    logic          pow_valid_in;
    logic          pow_ready_in;
    logic [15:0]   pow_data_out;
    logic          pow_valid_out;
    logic          pow_ready_out;
    logic [3:0]    outstanding;
    logic          idle;
    logic          err_orphan;

    int total = 0;
    int bad   = 0;

    pow_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .pow_data_in   (pow_data_in),
        .pow_valid_in  (pow_valid_in),
        .pow_ready_in  (pow_ready_in),
        .pow_data_out  (pow_data_out),
        .pow_valid_out (pow_valid_out),
        .pow_ready_out (pow_ready_out),
        .outstanding   (outstanding),
        .idle          (idle),
        .err_orphan    (err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cube(input logic [15:0] x);
        logic [15:0] r;
        r = x * x;
        r = r * x;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Operand sources: one small ring per requester, valid while non-empty.
    logic [15:0] src_data [4][16] = '{default: '0};
    logic [3:0]  src_head [4]     = '{default: 4'd0};
    logic [3:0]  src_tail [4]     = '{default: 4'd0};
    logic [15:0] lane_in  [4];
    logic [15:0] rsp_lane [4];

    for (genvar i = 0; i < NR; i++) begin : g_src
        assign req_valid[i] = (src_head[i] != src_tail[i]);
        assign lane_in[i]   = src_data[i][src_head[i]];
        assign rsp_lane[i]  = rsp_data[i*DW +: DW];
    end
    assign req_data = {lane_in[3], lane_in[2], lane_in[1], lane_in[0]};

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) src_head[i] <= src_head[i] + 4'd1;
        end
    end

    task automatic applyStimulus(input logic [1:0] lane, input logic [15:0] op);
        src_data[lane][src_tail[lane]] = op;
        src_tail[lane] = src_tail[lane] + 4'd1;
    endtask

    task automatic flushSources();
        for (int i = 0; i < NR; i++) src_tail[i] = src_head[i];
    endtask

    // Behavioural `pow`: elastic queue, result = operand cubed, each entry
    // becomes visible POW_LAT-1 cycles after acceptance.
    logic [15:0] pm_data [POW_CAP];
    int          pm_time [POW_CAP];
    int          pm_rd  = 0;
    int          pm_wr  = 0;
    int          pm_cnt = 0;
    int          cyc    = 0;
    logic        force_orphan = 1'b0;

    assign pow_ready_in  = (pm_cnt < POW_CAP);
    assign pow_valid_out = force_orphan || (pm_cnt > 0 && cyc >= pm_time[pm_rd]);
    assign pow_data_out  = (pm_cnt > 0) ? pm_data[pm_rd] : 16'hDEAD;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            pm_rd  <= 0;
            pm_wr  <= 0;
            pm_cnt <= 0;
        end else begin
            if (pow_valid_in && pow_ready_in) begin
                pm_data[pm_wr] <= cube(pow_data_in);
                pm_time[pm_wr] <= cyc + POW_LAT;
                pm_wr          <= (pm_wr + 1) % POW_CAP;
            end
            if (pow_valid_out && pow_ready_out && pm_cnt > 0) pm_rd <= (pm_rd + 1) % POW_CAP;
            pm_cnt <= pm_cnt + ((pow_valid_in && pow_ready_in) ? 1 : 0)
                             - ((pow_valid_out && pow_ready_out && pm_cnt > 0) ? 1 : 0);
        end
    end

    // Reference model and scoreboard, evaluated on the falling edge.
    exp_t        sb[$];
    exp_t        rsp_log[$];
    int          grant_log[$];
    logic [1:0]  m_rr     = 2'd0;
    logic        m_orphan = 1'b0;
    logic [1:0]  m_g, m_c, m_head;
    logic        m_found, m_any, m_issue, m_pvi, m_pro;
    logic [3:0]  m_exp_rr, m_exp_rv;
    int          m_size;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rst_req_ready", req_ready, 0);
            checkOutput("rst_pow_valid_in", pow_valid_in, 0);
            checkOutput("rst_rsp_valid", rsp_valid, 0);
            checkOutput("rst_pow_ready_out", pow_ready_out, 0);
            checkOutput("rst_outstanding", outstanding, 0);
            checkOutput("rst_idle", idle, 1);
            sb.delete();
            m_rr     = 2'd0;
            m_orphan = 1'b0;
        end else begin
            m_any   = |req_valid;
            m_size  = sb.size();
            m_g     = m_rr;
            m_found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                m_c = m_rr + 2'(k);
                if (!m_found && req_valid[m_c]) begin
                    m_g     = m_c;
                    m_found = 1'b1;
                end
            end
            m_pvi    = m_any && (m_size < 8);
            m_issue  = m_pvi && pow_ready_in;
            m_exp_rr = m_issue ? (4'b0001 << m_g) : 4'b0000;
            checkOutput("req_ready", req_ready, m_exp_rr);
            checkOutput("pow_valid_in", pow_valid_in, m_pvi);
            if (m_pvi) checkOutput("pow_data_in", pow_data_in, lane_in[m_g]);

            m_head   = (m_size > 0) ? sb[0].lane : 2'd0;
            m_exp_rv = (pow_valid_out && m_size > 0) ? (4'b0001 << m_head) : 4'b0000;
            m_pro    = (m_size > 0) && rsp_ready[m_head];
            checkOutput("rsp_valid", rsp_valid, m_exp_rv);
            checkOutput("pow_ready_out", pow_ready_out, m_pro);
            checkOutput("outstanding", outstanding, m_size);
            checkOutput("idle", idle, m_size == 0);
            checkOutput("err_orphan", err_orphan, m_orphan);

            if (pow_valid_out && m_pro) begin
                checkOutput("rsp_data", rsp_lane[m_head], sb[0].val);
                for (int k = 0; k < NR; k++) begin
                    if (rsp_valid[k] && rsp_ready[k]) begin
                        m_e.lane = 2'(k);
                        m_e.val  = rsp_lane[k];
                        rsp_log.push_back(m_e);
                    end
                end
                void'(sb.pop_front());
            end
            if (pow_valid_out && m_size == 0) m_orphan = 1'b1;
            if (m_issue) begin
                m_e.lane = m_g;
                m_e.val  = cube(lane_in[m_g]);
                sb.push_back(m_e);
                m_rr = m_g + 2'd1;
            end
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && req_ready[k]) grant_log.push_back(k);
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && req_valid == 4'b0) done = 1'b1;
        end
        checkOutput(tag, done, 1);
    endtask

    task automatic waitOutstanding(input string tag, input int target);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (outstanding == 4'(target)) done = 1'b1;
        end
        checkOutput(tag, done, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] exp_vals [8];
        exp_vals = '{16'd1, 16'd8, 16'd27, 16'd64, 16'd125, 16'd216, 16'd343, 16'd512};

        // Reset held for a few cycles, then released.
        repeat (3) stepCycle();
        @(negedge clk);
        checkOutput("init_outstanding", outstanding, 0);
        checkOutput("init_idle", idle, 1);
        stepCycle();
        rst = 1'b1;

        // All four requesters valid, two operands each.
        stepCycle();
        grant_log.delete();
        rsp_log.delete();
        for (int i = 0; i < NR; i++) begin
            applyStimulus(2'(i), 16'(i + 1));
            applyStimulus(2'(i), 16'(i + 5));
        end
        waitDrain("t1_drain");
        checkOutput("t1_idle", idle, 1);
        checkOutput("t1_grant_count", grant_log.size(), 8);
        checkOutput("t1_rsp_count", rsp_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < grant_log.size()) checkOutput($sformatf("t1_grant%0d", i), grant_log[i], i % 4);
            if (i < rsp_log.size()) begin
                checkOutput($sformatf("t1_rsp_lane%0d", i), rsp_log[i].lane, i % 4);
                checkOutput($sformatf("t1_rsp_val%0d", i), rsp_log[i].val, exp_vals[i]);
            end
        end

        // Lone requester 2, then lanes 0 and 3 together: search resumes at 3.
        stepCycle();
        grant_log.delete();
        rsp_log.delete();
        applyStimulus(2'd2, 16'd3);
        waitDrain("t2a_drain");
        stepCycle();
        applyStimulus(2'd0, 16'd2);
        applyStimulus(2'd3, 16'd4);
        waitDrain("t2b_drain");
        checkOutput("t2_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            checkOutput("t2_grant0", grant_log[0], 2);
            checkOutput("t2_grant1", grant_log[1], 3);
            checkOutput("t2_grant2", grant_log[2], 0);
        end
        if (rsp_log.size() > 0) begin
            checkOutput("t2_rsp_lane", rsp_log[0].lane, 2);
            checkOutput("t2_rsp_val", rsp_log[0].val, 27);
        end

        // Requester 1 stalls at the head until the tag FIFO fills.
        stepCycle();
        rsp_log.delete();
        rsp_ready = 4'b1101;
        applyStimulus(2'd1, 16'd2);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(2'd0, 16'(10 + j));
            applyStimulus(2'd2, 16'(20 + j));
            applyStimulus(2'd3, 16'(30 + j));
        end
        waitOutstanding("t3_fill", 8);
        checkOutput("t3_full_req_ready", req_ready, 0);
        repeat (2) stepCycle();
        @(negedge clk);
        checkOutput("t3_hold_outstanding", outstanding, 8);
        checkOutput("t3_hold_pow_ready_out", pow_ready_out, 0);
        stepCycle();
        rsp_ready = 4'hF;
        @(negedge clk);
        checkOutput("t3_full_retire_req_ready", req_ready, 0);
        checkOutput("t3_full_retire_pow_ready_out", pow_ready_out, 1);
        checkOutput("t3_full_retire_rsp_valid", rsp_valid, 4'b0010);
        stepCycle();
        checkOutput("t3_after_retire_outstanding", outstanding, 7);
        waitDrain("t3_drain");
        checkOutput("t3_rsp_count", rsp_log.size(), 13);
        if (rsp_log.size() > 0) begin
            checkOutput("t3_first_lane", rsp_log[0].lane, 1);
            checkOutput("t3_first_val", rsp_log[0].val, 8);
        end

        // Orphan result with nothing outstanding.
        stepCycle();
        force_orphan = 1'b1;
        @(negedge clk);
        checkOutput("t4_orphan_rsp_valid", rsp_valid, 0);
        checkOutput("t4_orphan_pow_ready_out", pow_ready_out, 0);
        checkOutput("t4_orphan_before", err_orphan, 0);
        stepCycle();
        force_orphan = 1'b0;
        checkOutput("t4_orphan_set", err_orphan, 1);
        repeat (3) stepCycle();
        checkOutput("t4_orphan_sticky", err_orphan, 1);

        // Reset with five operations in flight and more operands waiting.
        rsp_ready = 4'b0000;
        for (int j = 0; j < 4; j++) applyStimulus(2'd1, 16'(40 + j));
        for (int j = 0; j < 3; j++) applyStimulus(2'd3, 16'(50 + j));
        waitOutstanding("t5_fill", 4);
        stepCycle();
        checkOutput("t5_pre_rst_outstanding", outstanding, 5);
        rst       = 1'b0;
        rsp_ready = 4'hF;
        @(negedge clk);
        checkOutput("t5_rst_req_ready", req_ready, 0);
        checkOutput("t5_rst_pow_valid_in", pow_valid_in, 0);
        checkOutput("t5_rst_rsp_valid", rsp_valid, 0);
        checkOutput("t5_rst_pow_ready_out", pow_ready_out, 0);
        checkOutput("t5_rst_idle", idle, 1);
        stepCycle();
        rst = 1'b1;
        flushSources();
        checkOutput("t5_post_outstanding", outstanding, 0);
        checkOutput("t5_post_idle", idle, 1);
        checkOutput("t5_post_err_orphan", err_orphan, 0);
        grant_log.delete();
        for (int i = NR - 1; i >= 0; i--) applyStimulus(2'(i), 16'(i + 2));
        waitDrain("t5_drain");
        if (grant_log.size() > 0) checkOutput("t5_first_grant", grant_log[0], 0);
        checkOutput("t5_grant_count", grant_log.size(), 4);
        checkOutput("t5_final_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pow_arbiter.md
# pow_arbiter

Round-robin arbiter that shares one `pow` pipeline between `NUM_REQ` independent requesters in the cnn1d datapath. It grants one requester per accepted input beat and records the requester ID in an in-order tag FIFO. It then routes each `pow` result back to the requester that issued it. It also applies per-requester backpressure to the shared pipeline and reports occupancy and an orphan-result error.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, `cnn1d_pkg::DATA_WIDTH`: operand/result width.
- `TAG_DEPTH`, 8: maximum outstanding operations (power of 2, ≥ `pow` pipeline depth for full throughput).
- Derived `ID_W = $clog2(NUM_REQ)`, `CNT_W = $clog2(TAG_DEPTH+1)`.

Ports:
- `clk`  in  1  clock; reset `rst`, synchronous, active-low.
- `rst`  in  1  synchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester accept.
- `rsp_valid`  out  NUM_REQ  per-requester result valid.
- `rsp_data`  out  NUM_REQ*DATA_WIDTH  results; the same `pow_data_out` value is broadcast to all lanes.
- `rsp_ready`  in  NUM_REQ  per-requester result accept.
- `pow_data_in`  out  DATA_WIDTH  operand to `pow`.
- `pow_valid_in`  out  1  operand valid to `pow`.
- `pow_ready_in`  in  1  `pow` can accept an operand.
- `pow_data_out`  in  DATA_WIDTH  result from `pow`.
- `pow_valid_out`  in  1  result valid from `pow`.
- `pow_ready_out`  out  1  result accept to `pow`.
- `outstanding`  out  CNT_W  tag FIFO occupancy.
- `idle`  out  1  `outstanding==0`.
- `err_orphan`  out  1  sticky: a `pow` result arrived with the tag FIFO empty.

## Operation
- State:
  - `rr_ptr` (ID_W): next requester to get priority.
  - Tag FIFO of `TAG_DEPTH` × ID_W entries, with read/write pointers and `count`.
  - `err_orphan` flop.
- Arbitration (combinational):
  - `grant` is the first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap modulo NUM_REQ.
  - `issue = any(req_valid) && pow_ready_in && count<TAG_DEPTH`.
- Issue path:
  - `pow_valid_in = any(req_valid) && count<TAG_DEPTH`.
  - `pow_data_in = req_data[grant]`.
  - `req_ready[grant] = issue`; all other `req_ready` bits are 0.
- On `issue`:
  - Push `grant` into the tag FIFO.
  - `rr_ptr <= (grant+1) mod NUM_REQ`.
  - With no issue, `rr_ptr` holds.
- Return path, with `head` = tag FIFO read entry:
  - `rsp_valid[head] = pow_valid_out && count!=0`; other lanes are 0.
  - `pow_ready_out = count!=0 && rsp_ready[head]`.
  - `rsp_data` lanes all carry `pow_data_out`.
  - `retire = pow_valid_out && pow_ready_out` pops the FIFO.
- FIFO rules:
  - Push is blocked when `count==TAG_DEPTH`, even if a pop occurs in the same cycle.
  - Simultaneous push and pop with `0<count<TAG_DEPTH` leaves `count` unchanged.
  - Pointers wrap modulo TAG_DEPTH.
- Orphan detection:
  - `pow_valid_out && count==0` sets `err_orphan` (cleared only by reset).
  - No lane is asserted and `pow_ready_out` stays 0 in that case.
- Reset (`rst==0` at a clk edge):
  - `rr_ptr=0`, FIFO empty (`count=0`), `err_orphan=0`.
  - While `rst==0`, all handshake outputs (`req_ready`, `pow_valid_in`, `rsp_valid`, `pow_ready_out`) are forced to 0, and `outstanding=0`, `idle=1`.
  - Reset mid-operation discards all tags. `pow` must be reset in the same cycle; any stale result afterwards is flagged as orphan.

## Timing
- Zero-cycle combinational pass-through on both request and response paths. The block adds no latency; end-to-end latency equals the `pow` pipeline latency.
- Throughput is 1 op/cycle when `TAG_DEPTH` ≥ `pow` pipeline occupancy and all involved ready signals are high.
- `outstanding` and `idle` are registered-state outputs and reflect `count` after the last clock edge.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ accepted beats.
- A requester holding `req_valid` with stable data is granted within NUM_REQ issue opportunities.
- Results for the same requester return in issue order. Results across requesters return in global issue order.

## Test plan
- All four requesters valid, operands 1,2,3,4, `pow` POW=3, all ready high:
  - grant order 0,1,2,3,0,…
  - rsp lanes 0..3 receive 1, 8, 27, 64 in order.
  - `idle` returns to 1 after drain.
- Only requester 2 valid with operand 3, `rr_ptr=0`: requester 2 is granted immediately, and `rsp_valid[2]` carries 27 after the `pow` latency. The next grant starts the search at 3.
- `rsp_ready[1]=0` while its result is at the head:
  - `pow_ready_out=0`; the `pow` pipeline stalls and fills.
  - Issues continue until `outstanding=8`, then all `req_ready=0`.
  - Releasing `rsp_ready[1]` drains all results in order, each value matching operand³.
- Full FIFO (`count=8`) with a simultaneous retire: no push that cycle (`req_ready` all 0) and `outstanding` goes to 7.
- Force `pow_valid_out=1` with `count=0`: `err_orphan` goes to 1 next edge and stays 1; no `rsp_valid` is asserted; `pow_ready_out=0`.
- Assert `rst=0` for 1 cycle with 5 ops outstanding: the next cycle shows `outstanding=0`, `idle=1`, `rr_ptr=0`, `err_orphan=0`, and all handshake outputs were 0 during reset.
